// File: rtl/gray_sync_decoder.sv
// Gray-code receiver: synchronizes an asynchronous Gray count into clk, decodes
// it to binary, accepts single-bit steps into a running total and flags multi-bit jumps.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step,
  output logic                 dir,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 hd_err,
  output logic                 err_sticky,
  output logic [1:0]           state
);

  localparam int CW  = $clog2(SYNC_STAGES + 1);
  localparam int PCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PCW-1:0] c;
    c = {PCW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PCW'(v[i]);
    end
    return c;
  endfunction

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic [ACC_WIDTH-1:0] total_q, total_d;
  logic                 hd_q, hd_d;
  logic                 sticky_q, sticky_d;

  logic [WIDTH-1:0]     s_cur;
  logic [WIDTH-1:0]     diff;
  logic [PCW-1:0]       pc;
  logic [WIDTH-1:0]     bin_s;
  logic [WIDTH-1:0]     bin_p;
  logic                 is_up;

  // Plain flop chain: no logic between stages so each bit resolves independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_cur = sync_q[SYNC_STAGES-1];
  assign diff  = s_cur ^ p_q;
  assign pc    = popcount(diff);
  assign bin_s = gray2bin(s_cur);
  assign bin_p = gray2bin(p_q);
  assign is_up = (bin_s == (bin_p + WIDTH'(1)));

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    bin_d    = bin_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    total_d  = total_q;
    hd_d     = 1'b0;
    sticky_d = sticky_q;

    if (err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    case (state_q)
      ST_INIT: begin
        // The first sample only seeds the reference; it is never a step or an error.
        if (cnt_q == CW'(SYNC_STAGES)) begin
          p_d     = s_cur;
          bin_d   = bin_s;
          cnt_d   = {CW{1'b0}};
          state_d = ST_TRACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TRACK: begin
        if (pc == PCW'(1)) begin
          p_d    = s_cur;
          bin_d  = bin_s;
          step_d = 1'b1;
          dir_d  = is_up;
          if (is_up) begin
            total_d = total_q + ACC_WIDTH'(1);
          end else begin
            total_d = total_q - ACC_WIDTH'(1);
          end
        end else if (pc >= PCW'(2)) begin
          p_d      = s_cur;
          bin_d    = bin_s;
          hd_d     = 1'b1;
          sticky_d = 1'b1;
          state_d  = ST_FAULT;
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_FAULT: begin
        if (pc != PCW'(0)) begin
          p_d   = s_cur;
          bin_d = bin_s;
        end else begin
          p_d = p_q;
        end
        // A fresh multi-bit jump overrides a simultaneous clear request.
        if (pc >= PCW'(2)) begin
          hd_d     = 1'b1;
          sticky_d = 1'b1;
          state_d  = ST_FAULT;
        end else if (err_clr) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= {CW{1'b0}};
      p_q      <= {WIDTH{1'b0}};
      bin_q    <= {WIDTH{1'b0}};
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      total_q  <= {ACC_WIDTH{1'b0}};
      hd_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      bin_q    <= bin_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      total_q  <= total_d;
      hd_q     <= hd_d;
      sticky_q <= sticky_d;
    end
  end

  assign bin_out    = bin_q;
  assign step       = step_q;
  assign dir        = dir_q;
  assign total      = total_q;
  assign hd_err     = hd_q;
  assign err_sticky = sticky_q;
  assign state      = state_q;

  gray_sync_decoder_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .step       (step_q),
    .hd_err     (hd_q),
    .err_sticky (sticky_q),
    .state      (state_q)
  );

endmodule

// Output invariants of gray_sync_decoder.
module gray_sync_decoder_chk (
  input logic       clk,
  input logic       rst,
  input logic       step,
  input logic       hd_err,
  input logic       err_sticky,
  input logic [1:0] state
);

  a_excl: assert property (@(posedge clk) disable iff (rst) !(step && hd_err));
  a_step_track: assert property (@(posedge clk) disable iff (rst) step |-> (state == 2'd1));
  a_hd_fault: assert property (@(posedge clk) disable iff (rst) hd_err |-> (state == 2'd2 && err_sticky));
  a_legal: assert property (@(posedge clk) disable iff (rst) state != 2'd3);

endmodule
